tx_fcs_append: RTL and testbench

- Frame-formatting stage directly upstream of the half-duplex SNI transmitter's TX FIFO.
- Accepts frame bytes (destination MAC through payload) from the switch egress buffer over a valid/ready stream.
- Pads short frames to the minimum length and computes and appends the IEEE 802.3 CRC-32 FCS.
- Writes the result into the TX FIFO, flagging the final FCS byte with EOD so the transmitter can delimit frames.

---
 rtl/tx_fcs_append.sv | 169 ++++++++++++++++
 tb/tb_tx_fcs_append.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fcs_append.sv
// tx_fcs_append: pads short frames to MIN_LEN, appends the 802.3 CRC-32 FCS
// and writes the frame into the transmitter FIFO with EOD on the last byte.
// The FIFO write port (wren/din/EOD) is fully registered; in_ready is
// combinational so a byte can be taken every cycle while the FIFO has room.
module tx_fcs_append #(
  parameter int MIN_LEN      = 60,
  parameter bit TX_MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       fifo_afull,
  output logic       fifo_wren,
  output logic [7:0] fifo_din,
  output logic       fifo_EOD_in
);

  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAD  = 2'd2,
    S_FCS  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [10:0] cnt_reg, cnt_next;
  logic [1:0]  fcs_idx_reg, fcs_idx_next;
  logic        wren_reg, wren_next;
  logic [7:0]  din_reg, din_next;
  logic        eod_reg, eod_next;

  logic [7:0]  byte_next;   // byte produced this cycle, natural bit order
  logic [7:0]  byte_rev;    // same byte with bit 7 and bit 0 swapped etc.
  logic        xfer;
  logic        wr_en;
  logic [10:0] cnt_inc;
  logic [11:0] cnt_plus1;

  // LSB-first reflected CRC-32 update for one byte.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Only IDLE/DATA accept upstream bytes, and only while the FIFO has room;
  // held low while the block is in reset.
  assign in_ready  = arst_n && ((state_reg == S_IDLE) || (state_reg == S_DATA)) && !fifo_afull;
  assign xfer      = in_valid && in_ready;
  assign wr_en     = !fifo_afull;
  assign cnt_inc   = (cnt_reg == 11'h7FF) ? cnt_reg : cnt_reg + 11'd1;
  assign cnt_plus1 = {1'b0, cnt_reg} + 12'd1;

  // Serializer shifts bit 7 first, so optionally mirror every written byte.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign byte_rev[gi] = byte_next[7-gi];
  end
  assign din_next = TX_MSB_FIRST ? byte_rev : byte_next;

  // Next-state, CRC, counter and FIFO write decode.
  always_comb begin
    state_next   = state_reg;
    crc_next     = crc_reg;
    cnt_next     = cnt_reg;
    fcs_idx_next = fcs_idx_reg;
    wren_next    = 1'b0;
    byte_next    = 8'h00;
    eod_next     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        crc_next     = CRC_INIT;
        cnt_next     = 11'd0;
        fcs_idx_next = 2'd0;
        if (xfer) begin
          wren_next = 1'b1;
          byte_next = in_data;
          crc_next  = crc_byte(CRC_INIT, in_data);
          cnt_next  = 11'd1;
          if (in_last) begin
            state_next = (12'd1 < MIN_LEN_W) ? S_PAD : S_FCS;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wren_next = 1'b1;
          byte_next = in_data;
          crc_next  = crc_byte(crc_reg, in_data);
          cnt_next  = cnt_inc;
          if (in_last) begin
            state_next = (cnt_plus1 < MIN_LEN_W) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        if (wr_en) begin
          wren_next = 1'b1;
          byte_next = 8'h00;
          crc_next  = crc_byte(crc_reg, 8'h00);
          cnt_next  = cnt_inc;
          if (cnt_plus1 >= MIN_LEN_W) begin
            state_next = S_FCS;
          end
        end
      end
      S_FCS: begin
        // Emit the low byte of the inverted CRC, then shift the next one down.
        if (wr_en) begin
          wren_next    = 1'b1;
          byte_next    = ~crc_reg[7:0];
          crc_next     = {8'h00, crc_reg[31:8]};
          fcs_idx_next = fcs_idx_reg + 2'd1;
          if (fcs_idx_reg == 2'd3) begin
            eod_next     = 1'b1;
            state_next   = S_IDLE;
            crc_next     = CRC_INIT;
            cnt_next     = 11'd0;
            fcs_idx_next = 2'd0;
          end
        end
      end
      default: begin
        state_next   = S_IDLE;
        crc_next     = CRC_INIT;
        cnt_next     = 11'd0;
        fcs_idx_next = 2'd0;
      end
    endcase
  end

  // State and registered FIFO write port; reset drops any partial frame.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg   <= S_IDLE;
      crc_reg     <= CRC_INIT;
      cnt_reg     <= 11'd0;
      fcs_idx_reg <= 2'd0;
      wren_reg    <= 1'b0;
      din_reg     <= 8'h00;
      eod_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      crc_reg     <= crc_next;
      cnt_reg     <= cnt_next;
      fcs_idx_reg <= fcs_idx_next;
      wren_reg    <= wren_next;
      din_reg     <= din_next;
      eod_reg     <= eod_next;
    end
  end

  assign fifo_wren   = wren_reg;
  assign fifo_din    = din_reg;
  assign fifo_EOD_in = eod_reg;

endmodule

// File: tb/tb_tx_fcs_append.sv
// Scoreboard bench for tx_fcs_append: a frame-level reference model pushes the
// expected FIFO byte stream; a monitor pops and compares on every FIFO write.
module tb_tx_fcs_append;

  localparam int TB_MIN_LEN = 60;
  localparam bit TB_MSB     = 1'b1;

  typedef struct packed {
    logic [7:0] data;
    logic       eod;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       arst_n;
  logic       in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready;
  logic       afull_rand = 1'b0, afull_dir = 1'b0;
  logic       fifo_afull;
  logic       fifo_wren, fifo_eod;
  logic [7:0] fifo_din;
  logic       d0_ready, d0_wren, d0_eod;
  logic [7:0] d0_din;

  wr_t exp_q[$];
  wr_t q0[$];
  wr_t mon_e;
  int  checks = 0, errors = 0;
  int  cyc = 0, wr_count = 0, eod_cyc = 0;
  bit  tail = 0, tail_viol = 0, afull_prev = 0;
  bit  b2b_arm = 0, pend_b2b = 0, cap0 = 1;
  int  stall_mode = 0;

  always #5 clk = ~clk;
  assign fifo_afull = afull_rand | afull_dir;

  tx_fcs_append #(.MIN_LEN(TB_MIN_LEN), .TX_MSB_FIRST(TB_MSB)) u_dut (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .fifo_afull(fifo_afull),
    .fifo_wren(fifo_wren), .fifo_din(fifo_din), .fifo_EOD_in(fifo_eod)
  );

  // Unpadded, natural-order instance for the CRC known-answer frame.
  tx_fcs_append #(.MIN_LEN(0), .TX_MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(d0_ready), .fifo_afull(fifo_afull),
    .fifo_wren(d0_wren), .fifo_din(d0_din), .fifo_EOD_in(d0_eod)
  );

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = {<<{b}};
    return r;
  endfunction

  // Reference: pad with zeros, bit-serial CRC over the padded frame, append ~CRC.
  task automatic push_expected(input bq_t f);
    bq_t m;
    logic [31:0] crc, fcs;
    wr_t w;
    logic fb;
    m = f;
    while (m.size() < TB_MIN_LEN) m.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    foreach (m[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb  = crc[0] ^ m[k][i];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    fcs = ~crc;
    for (int j = 0; j < 4; j++) m.push_back(fcs[8*j +: 8]);
    foreach (m[k]) begin
      w.data = TB_MSB ? rev8(m[k]) : m[k];
      w.eod  = (k == m.size() - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Monitor: scoreboard pops, write gating, back-to-back spacing, in_ready in tail.
  always @(negedge clk) begin
    cyc++;
    if (tail && in_ready && !(fifo_wren && fifo_eod)) tail_viol = 1;
    if (fifo_wren) begin
      wr_count++;
      checks++;
      if (afull_prev) begin
        errors++;
        $display("FAIL gate: write at cycle %0d after afull=1, required no write", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got din=%02h eod=%0b, required no write", fifo_din, fifo_eod);
      end else begin
        mon_e = exp_q.pop_front();
        if (fifo_din !== mon_e.data || fifo_eod !== mon_e.eod) begin
          errors++;
          $display("FAIL wr_data: write %0d got din=%02h eod=%0b required din=%02h eod=%0b",
                   wr_count, fifo_din, fifo_eod, mon_e.data, mon_e.eod);
        end
      end
      if (pend_b2b) begin
        checks++;
        if (cyc != eod_cyc + 1) begin
          errors++;
          $display("FAIL b2b_gap: next frame write at cycle %0d, required %0d", cyc, eod_cyc + 1);
        end
        pend_b2b = 0;
      end
      if (fifo_eod) begin
        eod_cyc = cyc;
        if (b2b_arm) begin
          pend_b2b = 1;
          b2b_arm  = 0;
        end
        if (tail) begin
          checks++;
          if (tail_viol) begin
            errors++;
            $display("FAIL ready_tail: in_ready seen 1 between in_last and EOD, required 0");
          end
        end
        tail      = 0;
        tail_viol = 0;
      end
    end
    afull_prev = fifo_afull;
    if (cap0 && d0_wren) begin
      mon_e.data = d0_din;
      mon_e.eod  = d0_eod;
      q0.push_back(mon_e);
    end
  end

  // Random FIFO back-pressure.
  initial forever begin
    @(posedge clk);
    #1;
    afull_rand = (stall_mode == 1) && ($urandom_range(0, 3) == 0);
  end

  task automatic drive_byte(input logic [7:0] d, input bit last, input bit gaps);
    bit acc;
    int n;
    if (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 0;
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1;
    in_data  = d;
    in_last  = last;
    acc = 0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %02h not accepted within 300 cycles", d);
    end else if (last) begin
      tail = 1;
    end
  endtask

  task automatic send_frame(input bq_t f, input bit gaps, input bit arm);
    push_expected(f);
    foreach (f[i]) drive_byte(f[i], i == f.size() - 1, gaps);
    if (arm) b2b_arm = 1;
  endtask

  task automatic wait_done();
    int n;
    in_valid = 0;
    in_last  = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic stall_at(input int base, input int k);
    int n;
    n = 0;
    while (wr_count - base < k && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    afull_dir = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    afull_dir = 0;
  endtask

  function automatic bq_t rand_frame(input int len);
    bq_t f;
    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
    return f;
  endfunction

  initial begin
    bq_t f, f2;
    wr_t w;
    int base;
    logic [7:0] kat_d[13];
    kat_d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};

    arst_n = 0; in_valid = 0; in_last = 0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wren", 32'(fifo_wren), 0);
    chk("rst_din", 32'(fifo_din), 0);
    chk("rst_eod", 32'(fifo_eod), 0);
    arst_n = 1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 1);

    // "123456789": padded on the main DUT, known-answer on the unpadded one.
    f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(f, 0, 0);
    wait_done();
    cap0 = 0;
    chk("kat_writes", 32'(q0.size()), 13);
    for (int i = 0; i < 13 && i < q0.size(); i++) begin
      chk($sformatf("kat_byte%0d", i), 32'(q0[i].data), 32'(kat_d[i]));
      chk($sformatf("kat_eod%0d", i), 32'(q0[i].eod), (i == 12) ? 1 : 0);
    end

    // Short frame, then the same length with stalls in pad and in FCS.
    send_frame(rand_frame(14), 0, 0);
    wait_done();
    base = wr_count;
    fork
      send_frame(rand_frame(14), 0, 0);
      begin
        stall_at(base, 30);
        stall_at(base, 61);
      end
    join
    wait_done();

    // Back-to-back 64-byte frames with in_valid held high.
    f  = rand_frame(64);
    f2 = rand_frame(64);
    send_frame(f, 0, 1);
    send_frame(f2, 0, 0);
    wait_done();

    // Length boundaries around MIN_LEN.
    foreach (kat_d[i]) if (i < 4) begin
      send_frame(rand_frame((i == 0) ? 1 : 58 + i), 0, 0);
      wait_done();
    end

    // Random lengths, valid gaps and back-pressure.
    stall_mode = 1;
    for (int t = 0; t < 12; t++) begin
      send_frame(rand_frame($urandom_range(1, 120)), 1, 0);
      wait_done();
    end
    stall_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-payload: only the 10 written data bytes are expected, no EOD.
    f = rand_frame(30);
    for (int i = 0; i < 10; i++) begin
      w.data = TB_MSB ? rev8(f[i]) : f[i];
      w.eod  = 1'b0;
      exp_q.push_back(w);
    end
    for (int i = 0; i < 10; i++) drive_byte(f[i], 0, 0);
    @(negedge clk);
    #2;
    arst_n = 0;
    in_valid = 0;
    #1;
    chk("abort_wren", 32'(fifo_wren), 0);
    chk("abort_din", 32'(fifo_din), 0);
    chk("abort_eod", 32'(fifo_eod), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1;
    chk("abort_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
    send_frame(rand_frame(40), 0, 0);
    wait_done();

    repeat (5) @(posedge clk);
    chk("final_pending", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
